// File: rtl/dmem_access_pkg.sv
// ----------------------------------------------------------------------------
// dmem_access_pkg
//
// Shared definitions for the data-memory access controller: the controller
// state encoding, the byte-to-word address shift and default bus widths.
// ----------------------------------------------------------------------------
package dmem_access_pkg;

    // Default widths of the data and address buses.
    localparam int DATA_W_DEF  = 64;
    localparam int ADDR_W_DEF  = 64;
    localparam int DEPTH_DEF   = 32;

    // Words are 8 bytes, so a byte address becomes a word index with >> 3.
    localparam int WORD_SHIFT  = 3;

    // Controller states.
    //   IDLE   : waiting for a request, req_ready high
    //   SETUP  : address/data on the bus, strobes low
    //   ACCESS : selected strobe high for WAIT_CYCLES cycles
    //   HOLD   : strobes low, address/data still held
    //   RESP   : response offered until the consumer takes it
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4
    } state_e;

endpackage

// File: rtl/dmem_access_ctrl.sv
// ----------------------------------------------------------------------------
// dmem_access_ctrl
//
// Initiator side of the data-memory port. Takes LDUR/STUR requests from the
// memory stage over a valid/ready handshake, turns the byte address into a
// word index and runs a setup / strobe / hold sequence against the
// level-sensitive dmem. Load data and error status come back over a
// valid/ready response channel.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_write             1 = store, 0 = load
//   req_addr              byte address
//   req_wdata             store data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             load data (0 for stores and errors)
//   rsp_err               misaligned or out-of-range access
//   mem_addr, mem_idata   word index and write data towards dmem
//   MEMREAD, MEMWRITE     dmem strobes (never both high)
//   mem_odata             read data from dmem
// ----------------------------------------------------------------------------
module dmem_access_ctrl
    import dmem_access_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_idata,
    output logic              MEMREAD,
    output logic              MEMWRITE,
    input  logic [DATA_W-1:0] mem_odata
);

    localparam int               CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_e            state_q;
    logic              isWrite_q;
    logic [CNT_W-1:0]  waitCnt_q;
    logic              rspValid_q;
    logic              rspErr_q;
    logic [DATA_W-1:0] rspRdata_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [DATA_W-1:0] memIdata_q;
    logic              memRead_q;
    logic              memWrite_q;

    logic [ADDR_W-1:0] reqWordIdx;
    logic              reqErr;

    // Word index is the full shifted address so that the range check sees
    // every upper bit; an address beyond dmem is never silently wrapped.
    assign reqWordIdx = req_addr >> WORD_SHIFT;
    assign reqErr     = (req_addr[WORD_SHIFT-1:0] != '0) ||
                        (reqWordIdx >= ADDR_W'(DEPTH));

    assign req_ready  = (state_q == IDLE);

    // Single sequential block holding the state machine and every output.
    // The bus registers are only loaded from IDLE, so address and write
    // data cannot move while a strobe is high. rsp_valid is driven from
    // the RESP state itself, so it rises one edge after RESP is entered.
    // Reset clears the strobes asynchronously and drops the in-flight
    // request without a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            isWrite_q  <= 1'b0;
            waitCnt_q  <= '0;
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
            rspRdata_q <= '0;
            memAddr_q  <= '0;
            memIdata_q <= '0;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        isWrite_q  <= req_write;
                        memAddr_q  <= reqWordIdx;
                        memIdata_q <= req_wdata;
                        if (reqErr) begin
                            rspErr_q   <= 1'b1;
                            rspRdata_q <= '0;
                            state_q    <= RESP;
                        end else begin
                            state_q    <= SETUP;
                        end
                    end
                end

                SETUP: begin
                    memRead_q  <= !isWrite_q;
                    memWrite_q <= isWrite_q;
                    waitCnt_q  <= CNT_LOAD;
                    state_q    <= ACCESS;
                end

                ACCESS: begin
                    if (waitCnt_q == CNT_LAST) begin
                        memRead_q  <= 1'b0;
                        memWrite_q <= 1'b0;
                        rspRdata_q <= isWrite_q ? '0 : mem_odata;
                        state_q    <= HOLD;
                    end else begin
                        waitCnt_q  <= waitCnt_q - CNT_LAST;
                    end
                end

                HOLD: begin
                    state_q <= RESP;
                end

                RESP: begin
                    if (!rspValid_q) begin
                        rspValid_q <= 1'b1;
                    end else if (rsp_ready) begin
                        rspValid_q <= 1'b0;
                        rspErr_q   <= 1'b0;
                        rspRdata_q <= '0;
                        state_q    <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rspValid_q;
    assign rsp_err   = rspErr_q;
    assign rsp_rdata = rspRdata_q;
    assign mem_addr  = memAddr_q;
    assign mem_idata = memIdata_q;
    assign MEMREAD   = memRead_q;
    assign MEMWRITE  = memWrite_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dmem_access_ctrl
//
// Directed bench for dmem_access_ctrl with a behavioural dmem preloaded
// with word i = i*100, word 10 = 1540 and word 11 = 2117.
// ----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    localparam int DATA_W      = 64;
    localparam int ADDR_W      = 64;
    localparam int DEPTH       = 32;
    localparam int WAIT_CYCLES = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_idata;
    logic              MEMREAD;
    logic              MEMWRITE;
    logic [DATA_W-1:0] mem_odata;

    logic [63:0] memArr [0:31];

    int checkCount = 0;
    int passCount  = 0;

    int readCnt     = 0;
    int writeCnt    = 0;
    int bothCnt     = 0;
    int unstableCnt = 0;
    logic [63:0] strobeAddr = '0;
    logic [63:0] prevAddr   = '0;
    logic [63:0] prevData   = '0;

    int readBase;
    int writeBase;

    always #5 clk = ~clk;

    dmem_access_ctrl #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_idata (mem_idata),
        .MEMREAD   (MEMREAD),
        .MEMWRITE  (MEMWRITE),
        .mem_odata (mem_odata)
    );

    // Level-sensitive dmem: combinational read, write while MEMWRITE is high.
    assign mem_odata = (mem_addr < 64'd32) ? memArr[mem_addr[4:0]] : '0;

    initial begin
        for (int i = 0; i < 32; i++) memArr[i] = 64'(i * 100);
        memArr[10] = 64'd1540;
        memArr[11] = 64'd2117;
        forever begin
            @(posedge clk);
            if (MEMWRITE && (mem_addr < 64'd32)) memArr[mem_addr[4:0]] = mem_idata;
        end
    end

    // Strobe watcher: counts strobe cycles, the address seen under a strobe,
    // overlapping strobes and bus movement while a strobe is high.
    always @(negedge clk) begin
        if (MEMREAD)  readCnt  <= readCnt + 1;
        if (MEMWRITE) writeCnt <= writeCnt + 1;
        if (MEMREAD && MEMWRITE) bothCnt <= bothCnt + 1;
        if (MEMREAD || MEMWRITE) begin
            strobeAddr <= mem_addr;
            if ((mem_addr != prevAddr) || (mem_idata != prevData))
                unstableCnt <= unstableCnt + 1;
        end
        prevAddr <= mem_addr;
        prevData <= mem_idata;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Present one request at a negedge and return just after its accept edge.
    task automatic applyStimulus(input logic wr, input logic [63:0] addr, input logic [63:0] wdata);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) checkOutput("reqReadyTimeout", 64'd0, 64'd1);
        readBase  = readCnt;
        writeBase = writeCnt;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Count edges after the accept edge until rsp_valid is seen.
    task automatic waitResponse(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) checkOutput("rspTimeout", 64'd0, 64'd1);
    endtask

    task automatic runCheck(input string name, input logic wr, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [63:0] expData,
                            input logic expErr, input int expLat, input int expStrobes,
                            input logic [63:0] expStrobeAddr);
        int lat;
        applyStimulus(wr, addr, wdata);
        waitResponse(lat);
        checkOutput({name, ".latency"}, 64'(lat), 64'(expLat));
        checkOutput({name, ".rdata"}, rsp_rdata, expData);
        checkOutput({name, ".err"}, 64'(rsp_err), 64'(expErr));
        checkOutput({name, ".readStrobes"}, 64'(readCnt - readBase), wr ? 64'd0 : 64'(expStrobes));
        checkOutput({name, ".writeStrobes"}, 64'(writeCnt - writeBase), wr ? 64'(expStrobes) : 64'd0);
        if (expStrobes > 0) checkOutput({name, ".strobeAddr"}, strobeAddr, expStrobeAddr);
        @(posedge clk);
        #1;
        checkOutput({name, ".validDropped"}, 64'(rsp_valid), 64'd0);
        checkOutput({name, ".readyAgain"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        int  lat;
        logic sawValid;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        #12;
        checkOutput("reset.reqReady",  64'(req_ready), 64'd1);
        checkOutput("reset.rspValid",  64'(rsp_valid), 64'd0);
        checkOutput("reset.rspErr",    64'(rsp_err),   64'd0);
        checkOutput("reset.rspRdata",  rsp_rdata,      64'd0);
        checkOutput("reset.memAddr",   mem_addr,       64'd0);
        checkOutput("reset.memIdata",  mem_idata,      64'd0);
        checkOutput("reset.MEMREAD",   64'(MEMREAD),   64'd0);
        checkOutput("reset.MEMWRITE",  64'(MEMWRITE),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runCheck("load50",     1'b0, 64'h50,  64'd0,      64'd1540, 1'b0, 4, 1, 64'd10);
        runCheck("store58",    1'b1, 64'h58,  64'hDEAD,   64'd0,    1'b0, 4, 1, 64'd11);
        runCheck("load58",     1'b0, 64'h58,  64'd0,      64'hDEAD, 1'b0, 4, 1, 64'd11);
        runCheck("reload50",   1'b0, 64'h50,  64'd0,      64'd1540, 1'b0, 4, 1, 64'd10);
        runCheck("misaligned", 1'b0, 64'h53,  64'd0,      64'd0,    1'b1, 1, 0, 64'd0);
        runCheck("oorStore",   1'b1, 64'h100, 64'h1234,   64'd0,    1'b1, 1, 0, 64'd0);
        runCheck("oorHighBit", 1'b0, 64'h8000_0000_0000_0000, 64'd0, 64'd0, 1'b1, 1, 0, 64'd0);
        runCheck("load0",      1'b0, 64'h0,   64'd0,      64'd0,    1'b0, 4, 1, 64'd0);

        // Consumer stalls the response of a load of word 3.
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 64'h18, 64'd0);
        waitResponse(lat);
        checkOutput("stall.latency", 64'(lat), 64'd4);
        checkOutput("stall.rdata",   rsp_rdata, 64'd300);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("stall.valid",    64'(rsp_valid), 64'd1);
            checkOutput("stall.rdataHeld", rsp_rdata,     64'd300);
            checkOutput("stall.reqReady", 64'(req_ready), 64'd0);
        end

        // Release the stall while a new request is already waiting.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 64'h50;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("sameCycle.validDropped", 64'(rsp_valid), 64'd0);
        checkOutput("sameCycle.notAccepted",  64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        checkOutput("sameCycle.stillIdle", 64'(req_ready), 64'd1);

        // Reset arrives while a store to word 1 is strobing.
        applyStimulus(1'b1, 64'h08, 64'hBEEF);
        @(posedge clk);
        #1;
        checkOutput("rstMid.writeHigh", 64'(MEMWRITE), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstMid.MEMWRITE", 64'(MEMWRITE),  64'd0);
        checkOutput("rstMid.MEMREAD",  64'(MEMREAD),   64'd0);
        checkOutput("rstMid.reqReady", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        sawValid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            sawValid = sawValid | rsp_valid;
        end
        checkOutput("rstMid.noResponse", 64'(sawValid), 64'd0);
        runCheck("loadAfterRst", 1'b0, 64'h10, 64'd0, 64'd200, 1'b0, 4, 1, 64'd2);

        checkOutput("bus.bothStrobes", 64'(bothCnt),     64'd0);
        checkOutput("bus.unstable",    64'(unstableCnt), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
